count_arb_ctrl: RTL and testbench
=================================

COUNT_ARB_CTRL -- requirements
Module: count_arb_ctrl

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous reset, active-high (1 = reset) despite the name, sampled on clk.
REQ-004 req_valid  input  2  bit i = requester i wants a counting job; held high until accepted.
REQ-005 req_len0  input  8  job length (count cycles) for requester 0; sampled on accept.
REQ-006 req_len1  input  8  job length for requester 1; sampled on accept.
REQ-007 abort  input  1  terminate the current job early.
REQ-008 req_ready  output  2  bit i high = requester i accepted this cycle (combinational from state/pointer).
REQ-009 cnt_clr  output  1  clear strobe to the shared 8-bit counter.
REQ-010 cnt_en  output  1  increment enable to the shared counter.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 owner  output  1  index of the requester owning the counter; valid while busy.
REQ-013 done  output  2  one-cycle pulse on bit owner at job end.
REQ-014 aborted  output  1  high with the done pulse when the job ended by abort.

Function
REQ-015 FSM states: IDLE, CLEAR, RUN, DONE; 2-bit encoding, registered.
REQ-016 IDLE: no valid -> stay; any valid -> grant exactly one, req_ready[grant]=1 that cycle, latch owner and its len into 8-bit remain, next CLEAR.
REQ-017 Arbitration: both valid -> grant the requester != last_owner (round-robin); one valid -> grant it regardless of last_owner.
REQ-018 req_ready SHALL be 0 in every state except IDLE; never both bits high.
REQ-019 CLEAR: cnt_clr=1 for exactly one cycle; next RUN if remain!=0, else DONE.
REQ-020 RUN: cnt_en=1 every cycle; remain decrements by 1 per cycle; remain==1 -> next DONE.
REQ-021 Job of len N>0: exactly N cycles of cnt_en, contiguous; accept at T, cnt_clr at T+1, cnt_en T+2..T+1+N, done at T+2+N.
REQ-022 len=0: cnt_clr at T+1, no cnt_en, done at T+2.
REQ-023 abort in CLEAR or RUN -> next DONE with aborted=1; cnt_en deasserted from the cycle after abort; abort in IDLE/DONE ignored.
REQ-024 abort and remain==1 in the same RUN cycle -> DONE with aborted=1.
REQ-025 DONE: done[owner]=1 one cycle, aborted as latched, last_owner<=owner, next IDLE.
REQ-026 Earliest re-accept is the cycle after DONE (IDLE); back-to-back requests therefore alternate when both stay valid.
REQ-027 req_len changes after acceptance SHALL not affect the running job.
REQ-028 cnt_clr and cnt_en SHALL never be high in the same cycle.

Reset
REQ-029 rst_n=1 at a clk edge -> state IDLE, remain=0, owner=0, last_owner=1, aborted flag=0.
REQ-030 During and after reset: req_ready, cnt_clr, cnt_en, busy, done, aborted all 0.
REQ-031 Reset mid-job (CLEAR/RUN/DONE) -> next cycle IDLE, no done pulse, job discarded.
REQ-032 With rst_n=1 and req_valid=2'b11 -> req_ready=0 (reset has priority over grant).

Verification
REQ-033 Reset then req_valid=01, len0=3 -> ready=01 at T, cnt_clr T+1, cnt_en T+2..T+4, done=01 T+5, aborted=0.
REQ-034 req_valid=11 held, len0=2, len1=2 -> first grant req0, next grant req1, then req0; done pulses alternate 01,10,01.
REQ-035 req_valid=10, len1=0 -> cnt_clr T+1, no cnt_en, done=10 T+2.
REQ-036 len0=255 -> exactly 255 cnt_en cycles, done at T+257; len0=200, abort at 3rd cnt_en cycle -> 3 cnt_en total, done=01 with aborted=1 next cycle.
REQ-037 len0=10, rst_n=1 during 4th cnt_en cycle -> all outputs 0 next cycle, no done; new request afterwards served from IDLE normally.
REQ-038 Change req_len0 from 5 to 1 the cycle after accept -> still 5 cnt_en cycles; cnt_clr&cnt_en never both high across all tests.

Source files
------------

// File: rtl/count_arb_ctrl_if.sv
// Request handshake bundle for count_arb_ctrl: two requesters with their job lengths,
// plus the one-hot accept returned by the arbiter.
interface count_arb_ctrl_if;
  logic [1:0] req_valid;
  logic [7:0] req_len0;
  logic [7:0] req_len1;
  logic [1:0] req_ready;

  modport master (output req_valid, output req_len0, output req_len1, input req_ready);
  modport slave  (input req_valid, input req_len0, input req_len1, output req_ready);
endinterface

// File: rtl/count_arb_ctrl.sv
// Two-requester round-robin arbiter that owns a shared 8-bit counter for a job:
// clear once, enable for len cycles (or until abort), then pulse done to the owner.
module count_arb_ctrl (
  input  logic                   clk,
  input  logic                   rst_n,
  count_arb_ctrl_if.slave        req,
  input  logic                   abort,
  output logic                   cnt_clr,
  output logic                   cnt_en,
  output logic                   busy,
  output logic                   owner,
  output logic [1:0]             done,
  output logic                   aborted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] remain_q, remain_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic       ab_q, ab_d;

  logic       grant;
  logic [1:0] ready_c;
  logic       clr_c;
  logic       en_c;
  logic [1:0] done_c;
  logic       aborted_c;

  // Round-robin only matters when both ask; a lone requester always wins.
  assign grant = (&req.req_valid) ? ~last_q : req.req_valid[1];

  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    owner_d   = owner_q;
    last_d    = last_q;
    ab_d      = ab_q;
    ready_c   = '0;
    clr_c     = 1'b0;
    en_c      = 1'b0;
    done_c    = '0;
    aborted_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req.req_valid) begin
          ready_c  = grant ? 2'b10 : 2'b01;
          owner_d  = grant;
          remain_d = grant ? req.req_len1 : req.req_len0;
          ab_d     = 1'b0;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        clr_c = 1'b1;
        if (abort) begin
          ab_d    = 1'b1;
          state_d = DONE;
        end else if (remain_q != 8'd0) begin
          state_d = RUN;
        end else begin
          state_d = DONE;
        end
      end
      RUN: begin
        en_c     = 1'b1;
        remain_d = remain_q - 8'd1;
        if (abort) begin
          ab_d    = 1'b1;
          state_d = DONE;
        end else if (remain_q <= 8'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_c    = owner_q ? 2'b10 : 2'b01;
        aborted_c = ab_q;
        last_d    = owner_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= IDLE;
      remain_q <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      ab_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      ab_q     <= ab_d;
    end
  end

  // Reset (active-high) forces every strobe low even before the state register settles.
  assign req.req_ready = rst_n ? '0 : ready_c;
  assign cnt_clr       = ~rst_n & clr_c;
  assign cnt_en        = ~rst_n & en_c;
  assign busy          = ~rst_n & (state_q != IDLE);
  assign done          = rst_n ? '0 : done_c;
  assign aborted       = ~rst_n & aborted_c;
  assign owner         = owner_q;

endmodule

// File: tb/tb_count_arb_ctrl.sv
// Self-checking bench for count_arb_ctrl: job table plus hand sequences, with a
// negedge monitor that pops expected job results from a scoreboard at each done pulse.
module tb_count_arb_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       abort = 1'b0;
  logic       cnt_clr, cnt_en, busy, owner, aborted;
  logic [1:0] done;

  count_arb_ctrl_if bus();

  count_arb_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus),
    .abort   (abort),
    .cnt_clr (cnt_clr),
    .cnt_en  (cnt_en),
    .busy    (busy),
    .owner   (owner),
    .done    (done),
    .aborted (aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ready;
    int         en;
    logic       ab;
  } exp_t;

  typedef struct {
    logic [1:0] valid;
    logic [7:0] l0;
    logic [7:0] l1;
    int         abort_at;
    logic [1:0] ready;
    int         en;
    logic       ab;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   overlap = 0;
  int   stray_ab = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got timeout required event", name);
  endtask

  // Monitor: tracks the job currently in flight and checks it when done fires.
  logic       mon_active = 1'b0;
  int         t0, clr_at, en_cnt;
  logic [1:0] rdy_seen;
  exp_t       e;

  always @(negedge clk) begin
    cyc++;
    if (cnt_clr && cnt_en) overlap++;
    if (aborted && done == 2'b00) stray_ab++;
    if (rst_n) begin
      mon_active = 1'b0;
    end else begin
      if (bus.req_ready != 2'b00) begin
        t0 = cyc; clr_at = -100; en_cnt = 0;
        rdy_seen = bus.req_ready; mon_active = 1'b1;
      end
      if (cnt_clr) clr_at = cyc;
      if (cnt_en) en_cnt++;
      if (done != 2'b00) begin
        if (sb.size() == 0 || !mon_active) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_done: got %b required none", done);
        end else begin
          e = sb.pop_front();
          check("grant",        {30'd0, rdy_seen}, {30'd0, e.ready});
          check("done",         {30'd0, done},     {30'd0, e.ready});
          check("owner",        {31'd0, owner},    {31'd0, e.ready[1]});
          check("aborted",      {31'd0, aborted},  {31'd0, e.ab});
          check("en_cycles",    en_cnt,            e.en);
          check("clr_offset",   clr_at - t0,       1);
          check("done_latency", cyc - t0,          e.en + 2);
          mon_active = 1'b0;
        end
      end
    end
  end

  task automatic push_exp(input logic [1:0] r, input int n, input logic ab);
    exp_t x;
    x.ready = r; x.en = n; x.ab = ab;
    sb.push_back(x);
  endtask

  task automatic wait_ready(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_timeout("ready_wait");
  endtask

  // Waits for the done pulse; raises abort during the abort_at-th enable cycle.
  task automatic wait_done(input int abort_at);
    bit got = 1'b0;
    bit ab_sent = 1'b0;
    int k = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        got = 1'b1;
      end else begin
        if (cnt_en) k++;
        if (abort_at > 0 && !ab_sent && k == abort_at) begin
          abort = 1'b1;
          ab_sent = 1'b1;
          @(posedge clk); #1;
          abort = 1'b0;
        end
      end
    end
    if (!got) fail_timeout("done_wait");
    @(posedge clk); #1;
  endtask

  task automatic run_job(input vec_t v);
    bit got;
    bus.req_valid = v.valid;
    bus.req_len0  = v.l0;
    bus.req_len1  = v.l1;
    push_exp(v.ready, v.en, v.ab);
    wait_ready(got);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    if (!got) begin
      void'(sb.pop_back());
      return;
    end
    wait_done(v.abort_at);
  endtask

  vec_t tbl[9];

  initial begin
    bit got;
    int k, acc, dn;

    tbl[0] = '{2'b01, 8'd3,   8'd0, 0, 2'b01, 3,   1'b0};
    tbl[1] = '{2'b10, 8'd9,   8'd0, 0, 2'b10, 0,   1'b0};
    tbl[2] = '{2'b11, 8'd2,   8'd2, 0, 2'b01, 2,   1'b0};
    tbl[3] = '{2'b11, 8'd4,   8'd1, 0, 2'b10, 1,   1'b0};
    tbl[4] = '{2'b01, 8'd255, 8'd0, 0, 2'b01, 255, 1'b0};
    tbl[5] = '{2'b01, 8'd200, 8'd0, 3, 2'b01, 3,   1'b1};
    tbl[6] = '{2'b10, 8'd0,   8'd7, 7, 2'b10, 7,   1'b1};
    tbl[7] = '{2'b01, 8'd1,   8'd0, 0, 2'b01, 1,   1'b0};
    tbl[8] = '{2'b11, 8'd9,   8'd4, 0, 2'b10, 4,   1'b0};

    bus.req_valid = 2'b11;
    bus.req_len0  = 8'd3;
    bus.req_len1  = 8'd3;

    // Reset wins over a pending double request.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", {24'd0, bus.req_ready, cnt_clr, cnt_en, busy, done, aborted}, 32'd0);
    check("reset_owner", {31'd0, owner}, 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    rst_n = 1'b0;
    @(negedge clk);
    check("idle_outputs", {24'd0, bus.req_ready, cnt_clr, cnt_en, busy, done, aborted}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_job(tbl[i]);

    // Abort while idle is ignored.
    abort = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    abort = 1'b0;

    // Length changed after acceptance must not affect the job.
    bus.req_valid = 2'b01;
    bus.req_len0  = 8'd5;
    push_exp(2'b01, 5, 1'b0);
    wait_ready(got);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    bus.req_len0  = 8'd1;
    if (got) wait_done(0);
    else void'(sb.pop_back());

    // Reset during the 4th enable cycle discards the job.
    bus.req_valid = 2'b01;
    bus.req_len0  = 8'd10;
    wait_ready(got);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    k = 0;
    for (int i = 0; i < 30 && k < 3; i++) begin
      @(negedge clk);
      if (cnt_en) k++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", {24'd0, bus.req_ready, cnt_clr, cnt_en, busy, done, aborted}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    run_job('{2'b10, 8'd0, 8'd2, 0, 2'b10, 2, 1'b0});

    // Both held valid: grants alternate 0,1,0 (last owner was 1).
    push_exp(2'b01, 2, 1'b0);
    push_exp(2'b10, 2, 1'b0);
    push_exp(2'b01, 2, 1'b0);
    bus.req_valid = 2'b11;
    bus.req_len0  = 8'd2;
    bus.req_len1  = 8'd2;
    acc = 0;
    dn = 0;
    for (int i = 0; i < 100 && dn < 3; i++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) acc++;
      if (done != 2'b00) dn++;
      if (acc == 3 && bus.req_valid != 2'b00) begin
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
      end
    end
    if (dn < 3) fail_timeout("alternate_done");
    @(posedge clk); #1;

    check("clr_en_overlap", overlap, 0);
    check("stray_aborted", stray_ab, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
